// File: rtl/pixel_capture_sched_pkg.sv
// Shared encodings for the frame-capture scheduler: FSM states, bank states, pixel width.
package pixel_capture_sched_pkg;

    localparam int RGB565_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_COMMIT  = 2'd3
    } cap_state_e;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/pixel_capture_sched_pp_bank_tracker.sv
// Ping-pong bank ownership between the capture writer and the consumer:
// per-bank FREE/WRITING/FULL state, age order of FULL banks and free-bank selection.
module pp_bank_tracker
    import pixel_capture_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic alloc_i,
    input  logic alloc_bank_i,
    input  logic abort_i,
    input  logic abort_bank_i,
    input  logic commit_i,
    input  logic commit_bank_i,
    input  logic rd_done_i,
    output logic free_avail_o,
    output logic free_sel_o,
    output logic rd_valid_o,
    output logic rd_bank_o
);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        last_commit_q, last_commit_d;
    logic        order_q, order_d;
    logic        full0, full1;
    logic        preferred;
    logic        release_rd;

    assign full0        = (bank_q[0] == BANK_FULL);
    assign full1        = (bank_q[1] == BANK_FULL);
    assign preferred    = ~last_commit_q;
    assign free_avail_o = (bank_q[0] == BANK_FREE) || (bank_q[1] == BANK_FREE);
    assign free_sel_o   = (bank_q[preferred] == BANK_FREE) ? preferred : ~preferred;
    assign rd_valid_o   = full0 || full1;
    // With both banks full the order bit names the older one.
    assign rd_bank_o    = (full0 && full1) ? order_q : full1;
    assign release_rd   = rd_done_i && rd_valid_o;

    always_comb begin
        bank_d        = bank_q;
        last_commit_d = last_commit_q;
        order_d       = order_q;
        if (alloc_i) begin
            bank_d[alloc_bank_i] = BANK_WRITING;
        end
        if (abort_i) begin
            bank_d[abort_bank_i] = BANK_FREE;
        end
        if (release_rd) begin
            bank_d[rd_bank_o] = BANK_FREE;
        end
        if (commit_i) begin
            bank_d[commit_bank_i] = BANK_FULL;
            last_commit_d         = commit_bank_i;
            order_d = (bank_d[~commit_bank_i] == BANK_FULL) ? ~commit_bank_i : commit_bank_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q[0]     <= BANK_FREE;
            bank_q[1]     <= BANK_FREE;
            last_commit_q <= 1'b1;
            order_q       <= 1'b0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            last_commit_q <= last_commit_d;
            order_q       <= order_d;
        end
    end

endmodule

// File: rtl/pixel_capture_sched.sv
// Frame-capture scheduler: arms on request, aligns to frame start and writes one
// frame of downsampled pixels into a ping-pong bank shared with the LED/zone consumer.
module pixel_capture_sched
    import pixel_capture_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = RGB565_W,
    parameter int PIX_PER_FRAME = 49152,
    parameter int ADDR_W        = 16,
    parameter int TIMEOUT_CYC   = 2000000
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  cap_req,
    input  logic                  vs_i,
    input  logic                  pix_val_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  sampler_en,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic                  rd_bank,
    input  logic                  rd_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_timeout
);

    localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_PER_FRAME - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    cap_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  bank_q, bank_d;
    logic                  pending_q, pending_d;

    logic                  sampler_en_q;
    logic                  busy_q;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_bank_q;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  frame_done_q, frame_done_d;
    logic                  err_short_q, err_short_d;
    logic                  err_timeout_q, err_timeout_d;

    logic                  alloc, abort, commit;
    logic                  free_avail, free_sel;

    pp_bank_tracker u_bank_tracker (
        .clk_i         (video_clk),
        .rst_i         (rst),
        .alloc_i       (alloc),
        .alloc_bank_i  (free_sel),
        .abort_i       (abort),
        .abort_bank_i  (bank_q),
        .commit_i      (commit),
        .commit_bank_i (bank_q),
        .rd_done_i     (rd_done),
        .free_avail_o  (free_avail),
        .free_sel_o    (free_sel),
        .rd_valid_o    (rd_valid),
        .rd_bank_o     (rd_bank)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        bank_d        = bank_q;
        pending_d     = pending_q;
        alloc         = 1'b0;
        abort         = 1'b0;
        commit        = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = cnt_q;
        frame_done_d  = 1'b0;
        err_short_d   = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requests arriving while busy are absorbed by the capture in flight.
                pending_d = pending_q || cap_req;
                if (pending_q && free_avail) begin
                    alloc     = 1'b1;
                    bank_d    = free_sel;
                    timer_d   = TMR_LOAD;
                    pending_d = 1'b0;
                    state_d   = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (vs_i) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else if (timer_q == '0) begin
                    abort         = 1'b1;
                    err_timeout_d = 1'b1;
                    pending_d     = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (vs_i) begin
                    // Frame restart wins over a coincident pixel, which becomes pixel 0.
                    err_short_d = (cnt_q != '0);
                    cnt_d       = '0;
                    if (pix_val_i) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        cnt_d     = ADDR_W'(1);
                    end
                end else if (pix_val_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    if (cnt_q == LAST_PIX) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_COMMIT;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            timer_q       <= '0;
            bank_q        <= 1'b0;
            pending_q     <= 1'b0;
            sampler_en_q  <= 1'b0;
            busy_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            bank_q        <= bank_d;
            pending_q     <= pending_d;
            sampler_en_q  <= (state_d == ST_CAPTURE);
            busy_q        <= (state_d != ST_IDLE);
            wr_en_q       <= wr_en_d;
            wr_bank_q     <= bank_q;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= pix_data_i;
            frame_done_q  <= frame_done_d;
            err_short_q   <= err_short_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign sampler_en  = sampler_en_q;
    assign busy        = busy_q;
    assign wr_en       = wr_en_q;
    assign wr_bank     = wr_bank_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign err_short   = err_short_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pixel_capture_sched.sv
// Directed bench for pixel_capture_sched with an 8-pixel frame and a 20-cycle frame-start timeout.
module tb_pixel_capture_sched;

    localparam int DW   = 16;
    localparam int NPIX = 8;
    localparam int AW   = 16;
    localparam int TO   = 20;

    logic          video_clk = 1'b0;
    logic          rst, cap_req, vs_i, pix_val_i, rd_done;
    logic [DW-1:0] pix_data_i;
    logic          sampler_en, wr_en, wr_bank, rd_valid, rd_bank;
    logic          frame_done, busy, err_short, err_timeout;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 video_clk = ~video_clk;

    pixel_capture_sched #(
        .DATA_WIDTH    (DW),
        .PIX_PER_FRAME (NPIX),
        .ADDR_W        (AW),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .video_clk   (video_clk),
        .rst         (rst),
        .cap_req     (cap_req),
        .vs_i        (vs_i),
        .pix_val_i   (pix_val_i),
        .pix_data_i  (pix_data_i),
        .sampler_en  (sampler_en),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .rd_done     (rd_done),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_short   (err_short),
        .err_timeout (err_timeout)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_sampler_en"}, 32'(sampler_en), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_wr_en"}, 32'(wr_en), 0);
        check_val({tag, "_wr_bank"}, 32'(wr_bank), 0);
        check_val({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check_val({tag, "_wr_data"}, 32'(wr_data), 0);
        check_val({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check_val({tag, "_rd_bank"}, 32'(rd_bank), 0);
        check_val({tag, "_frame_done"}, 32'(frame_done), 0);
        check_val({tag, "_err_short"}, 32'(err_short), 0);
        check_val({tag, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    // cap_req pulse, one cycle to latch pending, one cycle to leave IDLE.
    task automatic start_cap();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        check_val("req_still_idle", 32'(busy), 0);
        tick();
        check_val("armed_busy", 32'(busy), 1);
    endtask

    task automatic push_pix(input int addr, input logic bank, input logic [DW-1:0] data, input logic last);
        pix_val_i  = 1'b1;
        pix_data_i = data;
        tick();
        pix_val_i  = 1'b0;
        check_val("pix_wr_en", 32'(wr_en), 1);
        check_val("pix_wr_addr", 32'(wr_addr), 32'(addr));
        check_val("pix_wr_bank", 32'(wr_bank), 32'(bank));
        check_val("pix_wr_data", 32'(wr_data), 32'(data));
        check_val("pix_frame_done", 32'(frame_done), 32'(last));
    endtask

    task automatic start_frame();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        check_val("cap_sampler_en", 32'(sampler_en), 1);
        check_val("cap_no_write", 32'(wr_en), 0);
    endtask

    task automatic run_frame(input logic bank, input logic [DW-1:0] base, input logic rd_at_commit);
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            push_pix(i, bank, base + DW'(i), (i == NPIX - 1));
        end
        if (rd_at_commit) rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check_val("post_busy", 32'(busy), 0);
        check_val("post_sampler_en", 32'(sampler_en), 0);
        check_val("post_wr_en", 32'(wr_en), 0);
        check_val("post_frame_done", 32'(frame_done), 0);
    endtask

    task automatic release_bank();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cap_req    = 1'b0;
        vs_i       = 1'b0;
        pix_val_i  = 1'b0;
        pix_data_i = '0;
        rd_done    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset");

        // First capture goes to bank 0.
        start_cap();
        run_frame(1'b0, 16'h0000, 1'b0);
        check_val("basic_rd_valid", 32'(rd_valid), 1);
        check_val("basic_rd_bank", 32'(rd_bank), 0);

        // Second capture fills bank 1; bank 0 stays the oldest.
        start_cap();
        run_frame(1'b1, 16'h0100, 1'b0);
        check_val("pp_rd_valid", 32'(rd_valid), 1);
        check_val("pp_rd_bank", 32'(rd_bank), 0);

        // Both banks full: request waits in IDLE until the consumer frees bank 0.
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("blocked_busy", 32'(busy), 0);
        end
        release_bank();
        check_val("freed_busy", 32'(busy), 0);
        check_val("freed_rd_bank", 32'(rd_bank), 1);
        tick();
        check_val("unblocked_busy", 32'(busy), 1);
        run_frame(1'b0, 16'h0200, 1'b0);
        check_val("third_rd_bank", 32'(rd_bank), 1);

        // Release bank 1, refill it while releasing bank 0 in the COMMIT cycle.
        release_bank();
        check_val("rel1_rd_valid", 32'(rd_valid), 1);
        check_val("rel1_rd_bank", 32'(rd_bank), 0);
        start_cap();
        run_frame(1'b1, 16'h0300, 1'b1);
        check_val("simul_rd_valid", 32'(rd_valid), 1);
        check_val("simul_rd_bank", 32'(rd_bank), 1);
        release_bank();
        check_val("empty_rd_valid", 32'(rd_valid), 0);

        // Short frame on bank 0: restart after 5 pixels.
        start_cap();
        start_frame();
        for (int i = 0; i < 5; i++) push_pix(i, 1'b0, 16'h0400 + 16'(i), 1'b0);
        check_val("short_pre_err", 32'(err_short), 0);
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        check_val("short_err_pulse", 32'(err_short), 1);
        check_val("short_vs_no_write", 32'(wr_en), 0);
        tick();
        check_val("short_err_width", 32'(err_short), 0);
        for (int i = 0; i < NPIX; i++) push_pix(i, 1'b0, 16'h0500 + 16'(i), (i == NPIX - 1));
        tick();
        check_val("short_after_fd", 32'(frame_done), 0);
        check_val("short_rd_bank", 32'(rd_bank), 0);
        check_val("short_busy", 32'(busy), 0);
        release_bank();

        // vs_i and pixel together on bank 1: pixel lands at addr 0.
        start_cap();
        start_frame();
        for (int i = 0; i < 3; i++) push_pix(i, 1'b1, 16'h0600 + 16'(i), 1'b0);
        vs_i = 1'b1;
        push_pix(0, 1'b1, 16'h06A0, 1'b0);
        vs_i = 1'b0;
        check_val("coinc_err_short", 32'(err_short), 1);
        for (int i = 1; i < NPIX; i++) push_pix(i, 1'b1, 16'h06A0 + 16'(i), (i == NPIX - 1));
        tick();
        check_val("coinc_rd_bank", 32'(rd_bank), 1);
        release_bank();
        check_val("coinc_released", 32'(rd_valid), 0);

        // Timeout: bank 0 allocated, no vs_i.
        start_cap();
        for (int k = 1; k < TO; k++) begin
            tick();
            if (k == TO - 1) begin
                check_val("to_early", 32'(err_timeout), 0);
                check_val("to_still_busy", 32'(busy), 1);
            end
        end
        tick();
        check_val("to_pulse", 32'(err_timeout), 1);
        check_val("to_busy", 32'(busy), 0);
        check_val("to_rd_valid", 32'(rd_valid), 0);
        tick();
        check_val("to_width", 32'(err_timeout), 0);
        start_cap();
        run_frame(1'b0, 16'h0700, 1'b0);
        check_val("to_reuse_bank", 32'(rd_bank), 0);

        // Reset in the middle of a bank-1 capture.
        start_cap();
        start_frame();
        for (int i = 0; i < 3; i++) push_pix(i, 1'b1, 16'h0800 + 16'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        tick();
        check_val("midrst_hold_valid", 32'(rd_valid), 0);
        start_cap();
        run_frame(1'b0, 16'h0900, 1'b0);
        check_val("midrst_rd_bank", 32'(rd_bank), 0);
        check_val("midrst_rd_valid", 32'(rd_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
